// File: rtl/mole_spawner.sv
// Whack-a-mole spawner: raises one pseudo-randomly chosen mole at a time for a speed-dependent window.
// Optional MOLE_NO_REPEAT_EN: consecutive selections are forced to differ.
module mole_spawner #(
   parameter int unsigned TICKS_PER_STEP = 25_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       game,
   input  logic [1:0] speed,
   input  logic [7:0] seed,
   input  logic       turnoff,
   output logic       mole1,
   output logic       mole2,
   output logic       mole3,
   output logic [7:0] hits,
   output logic [7:0] misses
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_GAP  = 2'd1;
   localparam logic [1:0] S_UP   = 2'd2;

   localparam int unsigned CW = $clog2(4 * TICKS_PER_STEP + 1);

   localparam logic [CW-1:0] GAP_LAST = CW'(TICKS_PER_STEP - 1);
   localparam logic [CW-1:0] UP_LAST0 = CW'(4 * TICKS_PER_STEP - 1);
   localparam logic [CW-1:0] UP_LAST1 = CW'(3 * TICKS_PER_STEP - 1);
   localparam logic [CW-1:0] UP_LAST2 = CW'(2 * TICKS_PER_STEP - 1);
   localparam logic [CW-1:0] UP_LAST3 = CW'(TICKS_PER_STEP - 1);

   logic [1:0]    state_q,   state_d;
   logic [CW-1:0] cnt_q,     cnt_d;
   logic [CW-1:0] up_last_q, up_last_d;
   logic [7:0]    lfsr_q,    lfsr_d;
   logic [2:0]    moles_q,   moles_d;
   logic [7:0]    hits_q,    hits_d;
   logic [7:0]    misses_q,  misses_d;

   logic [7:0]    lfsr_step;
   logic [1:0]    base_idx;
   logic [1:0]    pick_idx;
   logic          take;
   logic [CW-1:0] len_last;

   // Fibonacci LFSR, taps 8,6,5,4
   assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   assign base_idx = (lfsr_q[1:0] != 2'd3) ? lfsr_q[1:0] :
                     (lfsr_q[3:2] != 2'd3) ? lfsr_q[3:2] : 2'd0;

   assign take = game && (state_q == S_GAP) && (cnt_q == GAP_LAST);

`ifdef MOLE_NO_REPEAT_EN
   // 2'd3 encodes "no previous selection"
   logic [1:0] last_q, last_d;

   always_comb begin
      pick_idx = base_idx;
      if (base_idx == last_q) begin
         pick_idx = (base_idx == 2'd2) ? 2'd0 : base_idx + 2'd1;
      end
      last_d = last_q;
      if (take) begin
         last_d = pick_idx;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         last_q <= 2'd3;
      end else begin
         last_q <= last_d;
      end
   end
`else
   assign pick_idx = base_idx;
`endif

   always_comb begin
      unique case (speed)
         2'd0:    len_last = UP_LAST0;
         2'd1:    len_last = UP_LAST1;
         2'd2:    len_last = UP_LAST2;
         default: len_last = UP_LAST3;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      up_last_d = up_last_q;
      lfsr_d    = lfsr_q;
      moles_d   = moles_q;
      hits_d    = hits_q;
      misses_d  = misses_q;

      if (state_q != S_IDLE) begin
         lfsr_d = lfsr_step;
      end

      if (!game) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         moles_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               lfsr_d   = (seed == 8'h00) ? 8'hA5 : seed;
               hits_d   = '0;
               misses_d = '0;
               cnt_d    = '0;
               state_d  = S_GAP;
            end
            S_GAP: begin
               if (take) begin
                  state_d   = S_UP;
                  cnt_d     = '0;
                  up_last_d = len_last;
                  moles_d   = 3'b001 << pick_idx;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_UP: begin
               // a hit on the final cycle wins over the timeout
               if (turnoff) begin
                  if (hits_q != 8'hFF) begin
                     hits_d = hits_q + 8'd1;
                  end
                  state_d = S_GAP;
                  cnt_d   = '0;
                  moles_d = '0;
               end else if (cnt_q == up_last_q) begin
                  if (misses_q != 8'hFF) begin
                     misses_d = misses_q + 8'd1;
                  end
                  state_d = S_GAP;
                  cnt_d   = '0;
                  moles_d = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
               moles_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         up_last_q <= '0;
         lfsr_q    <= 8'h01;
         moles_q   <= '0;
         hits_q    <= '0;
         misses_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         up_last_q <= up_last_d;
         lfsr_q    <= lfsr_d;
         moles_q   <= moles_d;
         hits_q    <= hits_d;
         misses_q  <= misses_d;
      end
   end

   assign mole1  = moles_q[0];
   assign mole2  = moles_q[1];
   assign mole3  = moles_q[2];
   assign hits   = hits_q;
   assign misses = misses_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Bench for mole_spawner: behavioural board model checked every cycle, plus directed literal checks.
module tb_mole_spawner;

   localparam int unsigned T = 4;

   logic       clock   = 1'b0;
   logic       reset   = 1'b1;
   logic       game    = 1'b0;
   logic [1:0] speed   = 2'd0;
   logic [7:0] seed    = 8'h00;
   logic       turnoff = 1'b0;
   logic       mole1, mole2, mole3;
   logic [7:0] hits, misses;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   mole_spawner #(.TICKS_PER_STEP(T)) dut (
      .clock   (clock),
      .reset   (reset),
      .game    (game),
      .speed   (speed),
      .seed    (seed),
      .turnoff (turnoff),
      .mole1   (mole1),
      .mole2   (mole2),
      .mole3   (mole3),
      .hits    (hits),
      .misses  (misses)
   );

   always #5 clock = ~clock;

   // Behavioural model: the board is dark (off or between moles) or showing one mole,
   // with a countdown of cycles left in the current phase.
   typedef enum int {OFF, DARK, SHOW} phase_t;
   phase_t     m_phase = OFF;
   int         m_left  = 0;
   int         m_sel   = 0;
   int         m_last  = -1;
   int         m_hits  = 0;
   int         m_miss  = 0;
   int         m_b     = 0;
   logic [7:0] m_lfsr  = 8'h01;
   logic [7:0] m_cur   = 8'h01;

   function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
      return {v[6:0], ^(v & 8'hB8)};
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         m_phase = OFF;
         m_left  = 0;
         m_last  = -1;
         m_hits  = 0;
         m_miss  = 0;
         m_lfsr  = 8'h01;
      end else begin
         m_cur = m_lfsr;
         if (m_phase != OFF) m_lfsr = lfsr_adv(m_lfsr);
         if (!game) begin
            m_phase = OFF;
         end else begin
            case (m_phase)
               OFF: begin
                  m_lfsr  = (seed == 8'h00) ? 8'hA5 : seed;
                  m_hits  = 0;
                  m_miss  = 0;
                  m_phase = DARK;
                  m_left  = T;
               end
               DARK: begin
                  m_left = m_left - 1;
                  if (m_left == 0) begin
                     m_b = m_cur % 4;
                     if (m_b == 3) m_b = (m_cur / 4) % 4;
                     if (m_b == 3) m_b = 0;
`ifdef MOLE_NO_REPEAT_EN
                     if (m_b == m_last) m_b = (m_b + 1) % 3;
                     m_last = m_b;
`endif
                     m_sel   = m_b;
                     m_phase = SHOW;
                     m_left  = (4 - int'(speed)) * int'(T);
                  end
               end
               SHOW: begin
                  if (turnoff) begin
                     m_hits  = (m_hits < 255) ? m_hits + 1 : 255;
                     m_phase = DARK;
                     m_left  = T;
                  end else begin
                     m_left = m_left - 1;
                     if (m_left == 0) begin
                        m_miss  = (m_miss < 255) ? m_miss + 1 : 255;
                        m_phase = DARK;
                        m_left  = T;
                     end
                  end
               end
               default: m_phase = OFF;
            endcase
         end
      end
   end

   logic [2:0] e_moles;
   always @(negedge clock) begin
      if (chk_en) begin
         e_moles = '0;
         if (m_phase == SHOW) e_moles[2 - m_sel] = 1'b1;
         n_tests++;
         if ({mole1, mole2, mole3} !== e_moles || hits !== m_hits[7:0] || misses !== m_miss[7:0]) begin
            n_fail++;
            $display("FAIL outputs @%0t: got moles=%b hits=%0d misses=%0d, expected moles=%b hits=%0d misses=%0d",
                     $time, {mole1, mole2, mole3}, hits, misses, e_moles, m_hits, m_miss);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   function automatic bit any_up();
      return mole1 | mole2 | mole3;
   endfunction

   task automatic wait_up(input string what, output int idx);
      int n;
      n   = 0;
      idx = -1;
      while (!any_up() && n < 64) begin
         step();
         n++;
      end
      if (any_up()) begin
         idx = mole1 ? 0 : (mole2 ? 1 : 2);
      end else begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: no mole rose within 64 cycles", what);
      end
   endtask

   task automatic wait_down(input string what);
      int n;
      n = 0;
      while (any_up() && n < 64) begin
         step();
         n++;
      end
      if (any_up()) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: mole still up after 64 cycles", what);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

   int idx, n, prev, h_keep;
   int seqa[12];
   int seqb[12];

   initial begin
      repeat (3) step();
      chk_en = 1'b1;
      check("reset_moles", {mole1, mole2, mole3}, 0);
      check("reset_hits", hits, 0);
      check("reset_misses", misses, 0);
      reset = 1'b0;
      step();

      // seed 0 -> A5; after three advances the LFSR reads 8'h2A, index 2 -> mole3
      game  = 1'b1;
      seed  = 8'h00;
      speed = 2'd3;
      for (int i = 0; i < 4; i++) begin
         step();
         check("dark_before_first", {mole1, mole2, mole3}, 0);
      end
      step();
      check("first_mole_is_mole3", {mole1, mole2, mole3}, 3'b001);

      n = 1;
      step();
      while (any_up() && n < 50) begin
         n++;
         step();
      end
      check("speed3_up_cycles", n, 4);
      check("speed3_miss", misses, 1);
      check("speed3_hits", hits, 0);
      n = 1;
      step();
      while (!any_up() && n < 50) begin
         n++;
         step();
      end
      check("gap_cycles", n, 4);

      // fresh game, speed 0, hit on third UP cycle
      game = 1'b0;
      step();
      check("stop_moles", {mole1, mole2, mole3}, 0);
      check("stop_holds_misses", misses, 1);
      game  = 1'b1;
      speed = 2'd0;
      seed  = 8'h3C;
      step();
      check("restart_clears_misses", misses, 0);
      wait_up("hit_wait", idx);
      step();
      step();
      turnoff = 1'b1;
      step();
      turnoff = 1'b0;
      check("hit_drops_mole", {mole1, mole2, mole3}, 0);
      check("hit_count", hits, 1);
      check("hit_no_miss", misses, 0);

      turnoff = 1'b1;
      step();
      turnoff = 1'b0;
      check("gap_turnoff_ignored", hits, 1);
      game = 1'b0;
      step();
      turnoff = 1'b1;
      step();
      turnoff = 1'b0;
      check("idle_turnoff_ignored", hits, 1);

      // turnoff on the final UP cycle counts as a hit
      game  = 1'b1;
      speed = 2'd3;
      wait_up("coincide_wait", idx);
      step();
      step();
      step();
      turnoff = 1'b1;
      step();
      turnoff = 1'b0;
      check("coincide_hits", hits, 1);
      check("coincide_misses", misses, 0);

      // late pulse after a timeout leaves the miss in place
      wait_up("late_wait", idx);
      repeat (4) step();
      check("late_timeout_dropped", {mole1, mole2, mole3}, 0);
      turnoff = 1'b1;
      step();
      turnoff = 1'b0;
      check("late_hits", hits, 1);
      check("late_misses", misses, 1);

      for (int k = 0; k < 300; k++) begin
         wait_up("sat_miss_up", idx);
         wait_down("sat_miss_down");
      end
      check("misses_saturate", misses, 255);

      wait_up("midup_wait", idx);
      step();
      h_keep = hits;
      game = 1'b0;
      step();
      check("midup_stop_moles", {mole1, mole2, mole3}, 0);
      check("midup_hold_misses", misses, 255);
      check("midup_hold_hits", hits, h_keep);
      game = 1'b1;
      step();
      check("restart_hits_clear", hits, 0);
      check("restart_misses_clear", misses, 0);

      speed = 2'd0;
      for (int k = 0; k < 260; k++) begin
         wait_up("sat_hit_up", idx);
         turnoff = 1'b1;
         step();
         turnoff = 1'b0;
      end
      check("hits_saturate", hits, 255);
      check("hits_sat_misses", misses, 0);

`ifdef MOLE_NO_REPEAT_EN
      speed = 2'd3;
      prev  = -1;
      for (int k = 0; k < 100; k++) begin
         wait_up("norepeat_up", idx);
         if (k > 0) begin
            n_tests++;
            if (idx == prev) begin
               n_fail++;
               $display("FAIL norepeat: mole %0d repeated at selection %0d, required a different index", idx, k);
            end
         end
         prev = idx;
         wait_down("norepeat_down");
      end
`else
      game = 1'b0;
      step();
      seed  = 8'h5B;
      speed = 2'd3;
      game  = 1'b1;
      for (int k = 0; k < 12; k++) begin
         wait_up("repro_a_up", seqa[k]);
         wait_down("repro_a_down");
      end
      game = 1'b0;
      step();
      game = 1'b1;
      for (int k = 0; k < 12; k++) begin
         wait_up("repro_b_up", seqb[k]);
         check("repro_sequence", seqb[k], seqa[k]);
         wait_down("repro_b_down");
      end
`endif

      for (int i = 0; i < 3000; i++) begin
         step();
         reset   = ($urandom_range(0, 599) == 0);
         game    = ($urandom_range(0, 99) < 97);
         speed   = 2'($urandom_range(0, 3));
         seed    = 8'($urandom_range(0, 255));
         turnoff = ($urandom_range(0, 5) == 0);
      end
      reset   = 1'b0;
      turnoff = 1'b0;
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
